// File: rtl/xram_pkg.sv
// Shared types for the two-port external RAM arbiter.
// Holds the FSM encoding and the requester identifiers.
package xram_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_C    = 2'd1,
        OWN_D    = 2'd2,
        HANDOVER = 2'd3
    } state_e;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    function automatic port_e other(input port_e p);
        return (p == PORT_C) ? PORT_D : PORT_C;
    endfunction

    function automatic state_e own_state(input port_e p);
        return (p == PORT_C) ? OWN_C : OWN_D;
    endfunction

endpackage

// File: rtl/xram_if.sv
// CPU port, DMA port and single-port RAM bus of the arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface xram_if #(
    parameter int AW = 16
);
    logic          c_req;
    logic          c_we;
    logic          c_lock;
    logic [AW-1:0] c_addr;
    logic [7:0]    c_wdata;
    logic          c_gnt;
    logic          c_rvalid;
    logic [7:0]    c_rdata;

    logic          d_req;
    logic          d_we;
    logic          d_lock;
    logic [AW-1:0] d_addr;
    logic [7:0]    d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [7:0]    d_rdata;

    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data;
    logic          ram_wren;
    logic [7:0]    ram_q;

    modport slave (
        input  c_req, c_we, c_lock, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_address, ram_data, ram_wren,
        input  ram_q
    );

    modport master (
        output c_req, c_we, c_lock, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_address, ram_data, ram_wren,
        output ram_q
    );

endinterface

// File: rtl/xram_port_mux.sv
// Combinational owner select of the access fields.
module xram_port_mux
    import xram_pkg::*;
#(
    parameter int AW = 16
) (
    input  port_e         sel_i,
    input  logic [AW-1:0] c_addr_i,
    input  logic [7:0]    c_wdata_i,
    input  logic          c_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [7:0]    d_wdata_i,
    input  logic          d_we_i,
    output logic [AW-1:0] addr_o,
    output logic [7:0]    wdata_o,
    output logic          we_o
);

    always_comb begin
        addr_o  = c_addr_i;
        wdata_o = c_wdata_i;
        we_o    = c_we_i;
        if (sel_i == PORT_D) begin
            addr_o  = d_addr_i;
            wdata_o = d_wdata_i;
            we_o    = d_we_i;
        end
    end

endmodule

// File: rtl/xram_arbiter.sv
// CPU/DMA arbiter for a single-port RAM with locked bursts,
// bounded burst length and a one-cycle handover gap.
module xram_arbiter
    import xram_pkg::*;
#(
    parameter int AW        = 16,
    parameter int MAX_BURST = 16
) (
    input  logic  clock,
    input  logic  reset_n,
    xram_if.slave bus
);

    localparam int CW = $clog2(MAX_BURST) + 1;

    state_e        state_q, state_d;
    port_e         last_q, last_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    port_e         own;
    logic          own_vld;
    logic          o_req, o_lock, x_req;
    logic          issue;
    logic [AW-1:0] mux_addr, addr_q;
    logic [7:0]    mux_wdata, data_q;
    logic          mux_we;
    logic          rd_q;
    port_e         rd_port_q;
    logic [7:0]    c_rdata_q, d_rdata_q;
    logic          c_rv, d_rv;

    // IDLE grants the winner in the same cycle it requests
    always_comb begin
        own     = PORT_C;
        own_vld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.c_req && (!bus.d_req || last_q == PORT_D)) begin
                    own_vld = 1'b1;
                end else if (bus.d_req) begin
                    own     = PORT_D;
                    own_vld = 1'b1;
                end
            end
            OWN_C:    own_vld = 1'b1;
            OWN_D: begin
                own     = PORT_D;
                own_vld = 1'b1;
            end
            HANDOVER: own_vld = 1'b0;
            default:  own_vld = 1'b0;
        endcase
        own_vld = own_vld & reset_n;
        o_req   = (own == PORT_D) ? bus.d_req  : bus.c_req;
        o_lock  = (own == PORT_D) ? bus.d_lock : bus.c_lock;
        x_req   = (own == PORT_D) ? bus.c_req  : bus.d_req;
        issue   = own_vld & o_req;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d     = own_state(own);
                    burst_cnt_d = CW'(1);
                end
            end
            OWN_C, OWN_D: begin
                if (!o_req || !o_lock) begin
                    state_d     = IDLE;
                    last_d      = own;
                    burst_cnt_d = '0;
                end else if (int'(burst_cnt_q) + 1 >= MAX_BURST) begin
                    burst_cnt_d = '0;
                    if (x_req) begin
                        state_d = HANDOVER;
                        last_d  = own;
                    end
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            HANDOVER: begin
                state_d     = own_state(other(last_q));
                burst_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    xram_port_mux #(.AW(AW)) u_mux (
        .sel_i    (own),
        .c_addr_i (bus.c_addr),
        .c_wdata_i(bus.c_wdata),
        .c_we_i   (bus.c_we),
        .d_addr_i (bus.d_addr),
        .d_wdata_i(bus.d_wdata),
        .d_we_i   (bus.d_we),
        .addr_o   (mux_addr),
        .wdata_o  (mux_wdata),
        .we_o     (mux_we)
    );

    assign bus.c_gnt       = issue & (own == PORT_C);
    assign bus.d_gnt       = issue & (own == PORT_D);
    assign bus.ram_wren    = issue & mux_we;
    assign bus.ram_address = issue ? mux_addr : addr_q;
    assign bus.ram_data    = issue ? mux_wdata : data_q;

    assign c_rv         = rd_q & (rd_port_q == PORT_C);
    assign d_rv         = rd_q & (rd_port_q == PORT_D);
    assign bus.c_rvalid = c_rv;
    assign bus.d_rvalid = d_rv;
    assign bus.c_rdata  = c_rv ? bus.ram_q : c_rdata_q;
    assign bus.d_rdata  = d_rv ? bus.ram_q : d_rdata_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_q      <= PORT_D;
            burst_cnt_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rd_q        <= 1'b0;
            rd_port_q   <= PORT_C;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            addr_q      <= bus.ram_address;
            data_q      <= bus.ram_data;
            rd_q        <= issue & ~mux_we;
            rd_port_q   <= own;
            if (c_rv) c_rdata_q <= bus.ram_q;
            if (d_rv) d_rdata_q <= bus.ram_q;
        end
    end

endmodule

// File: tb/tb_xram_arbiter.sv
// Directed bench for xram_arbiter with a behavioural RAM
// (registered address, one-cycle read latency).
module tb_xram_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] mem [0:65535];
    logic [5:0] pat;
    logic       exp_crv, exp_drv;

    xram_if #(.AW(16)) bus ();

    xram_arbiter #(.AW(16), .MAX_BURST(16)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic sample;
        @(negedge clock);
    endtask

    task automatic quiet;
        bus.c_req = 0; bus.c_we = 0; bus.c_lock = 0;
        bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_lock = 0;
        bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'h5A;
        mem[16'h2001] = 8'h3C;
        reset_n = 1'b0;
        quiet();
        bus.c_req = 1;

        // reset values, grant suppressed while in reset
        sample();
        chk("rst_cgnt", bus.c_gnt, 0);
        chk("rst_dgnt", bus.d_gnt, 0);
        chk("rst_crv", bus.c_rvalid, 0);
        chk("rst_crd", bus.c_rdata, 0);
        chk("rst_drd", bus.d_rdata, 0);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_addr", bus.ram_address, 0);
        tick();
        reset_n = 1'b1;
        quiet();

        // single CPU read
        bus.c_req = 1; bus.c_addr = 16'h1234;
        sample();
        chk("rd_cgnt", bus.c_gnt, 1);
        chk("rd_addr", bus.ram_address, 16'h1234);
        chk("rd_wren", bus.ram_wren, 0);
        tick();
        bus.c_req = 0; bus.c_addr = 16'h0BAD;
        sample();
        chk("rd_crv", bus.c_rvalid, 1);
        chk("rd_crd", bus.c_rdata, 8'h5A);
        chk("rd_drv", bus.d_rvalid, 0);
        chk("rd_hold_addr", bus.ram_address, 16'h1234);
        tick();
        sample();
        chk("rd_crv_off", bus.c_rvalid, 0);
        chk("rd_crd_hold", bus.c_rdata, 8'h5A);
        tick();

        // CPU write: no rvalid
        bus.c_req = 1; bus.c_we = 1;
        bus.c_addr = 16'h0042; bus.c_wdata = 8'h77;
        sample();
        chk("wr_wren", bus.ram_wren, 1);
        chk("wr_data", bus.ram_data, 8'h77);
        tick();
        quiet();
        sample();
        chk("wr_norv", bus.c_rvalid, 0);
        tick();

        // tie from reset: CPU first, then turns alternate
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.c_req = 1; bus.c_addr = 16'h1234;
        bus.d_req = 1; bus.d_addr = 16'h2001;
        pat = 6'b110011;
        for (int k = 0; k < 6; k++) begin
            sample();
            chk("tie_cgnt", bus.c_gnt, pat[5-k]);
            chk("tie_dgnt", bus.d_gnt, !pat[5-k]);
            if (k > 0) chk("tie_crv", bus.c_rvalid, pat[6-k]);
            if (k == 3) chk("tie_drd", bus.d_rdata, 8'h3C);
            tick();
        end
        quiet();
        tick();

        // locked DMA burst forced to hand over to a waiting CPU
        bus.d_req = 1; bus.d_lock = 1; bus.d_addr = 16'h2001;
        bus.c_req = 1; bus.c_addr = 16'h1234;
        for (int k = 0; k < 20; k++) begin
            sample();
            chk("brst_dgnt", bus.d_gnt, (k < 16) || (k >= 18));
            chk("brst_cgnt", bus.c_gnt, k == 17);
            tick();
        end
        quiet();
        tick();

        // locked DMA writes with CPU idle: wrap, no handover
        bus.d_req = 1; bus.d_lock = 1; bus.d_we = 1;
        for (int k = 0; k < 20; k++) begin
            bus.d_addr  = 16'h3000 + 16'(k);
            bus.d_wdata = 8'(k);
            sample();
            chk("wrap_dgnt", bus.d_gnt, 1);
            chk("wrap_wren", bus.ram_wren, 1);
            chk("wrap_cnt", dut.burst_cnt_q, k % 16);
            tick();
        end
        quiet();
        tick();
        bus.c_req = 1; bus.c_addr = 16'h3013;
        sample();
        chk("wrap_rd_gnt", bus.c_gnt, 1);
        tick();
        bus.c_req = 0;
        sample();
        chk("wrap_rd_data", bus.c_rdata, 8'h13);
        tick();

        // reset the cycle after a granted read
        bus.c_req = 1; bus.c_addr = 16'h1234;
        sample();
        chk("prst_cgnt", bus.c_gnt, 1);
        tick();
        reset_n = 1'b0;
        sample();
        chk("prst_crv", bus.c_rvalid, 0);
        chk("prst_cgnt0", bus.c_gnt, 0);
        chk("prst_crd", bus.c_rdata, 0);
        chk("prst_addr", bus.ram_address, 0);
        chk("prst_wren", bus.ram_wren, 0);
        tick();
        reset_n = 1'b1;
        quiet();
        sample();
        chk("prst_crv_after", bus.c_rvalid, 0);
        tick();

        // random traffic: exclusive grants, one rvalid per read
        exp_crv = 0;
        exp_drv = 0;
        for (int k = 0; k < 200; k++) begin
            bus.c_req   = 1'($urandom_range(0, 1));
            bus.c_we    = 1'($urandom_range(0, 1));
            bus.c_lock  = ($urandom_range(0, 3) == 0);
            bus.c_addr  = 16'($urandom);
            bus.c_wdata = 8'($urandom);
            bus.d_req   = 1'($urandom_range(0, 1));
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_lock  = ($urandom_range(0, 1) == 0);
            bus.d_addr  = 16'($urandom);
            bus.d_wdata = 8'($urandom);
            sample();
            chk("rnd_mutex", bus.c_gnt & bus.d_gnt, 0);
            chk("rnd_crv", bus.c_rvalid, exp_crv);
            chk("rnd_drv", bus.d_rvalid, exp_drv);
            exp_crv = bus.c_gnt & ~bus.c_we;
            exp_drv = bus.d_gnt & ~bus.d_we;
            tick();
        end
        quiet();
        sample();
        chk("rnd_crv_last", bus.c_rvalid, exp_crv);
        chk("rnd_drv_last", bus.d_rvalid, exp_drv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
